// File: rtl/spi_master.sv
// SPI mode-0 master issuing 40-bit register-access frames: {wr, 3'b000, addr} header, 32 data bits.
// MISO bits 9..40 are returned as rdata when the frame completes.
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        SPI_CLK,
  output logic        SPI_CS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold, StGap} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [5:0] NumBits = 6'd40;

  state_e      state_q, state_d;
  logic [39:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_end;

  assign div_end = (div_cnt_q == DivLast);

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    div_cnt_d = div_end ? 8'd0 : div_cnt_q + 8'd1;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        div_cnt_d = 8'd0;
        if (start) begin
          tx_d      = {wr, 3'b000, addr, wdata};
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = 6'd0;
          state_d   = StSetup;
        end
      end
      StSetup, StLow: begin
        if (div_end) begin
          if (state_q == StLow && bit_cnt_q == NumBits) begin
            state_d = StHold;
          end else begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 6'd1;
            state_d   = StHigh;
            // The edge being raised is bit bit_cnt_q+1; keep only bits 9..40.
            if (bit_cnt_q >= 6'd8) rx_d = {rx_q[30:0], SPI_MISO};
          end
        end
      end
      StHigh: begin
        if (div_end) begin
          sclk_d  = 1'b0;
          // Zero fill leaves MOSI low once all 40 bits are out.
          tx_d    = {tx_q[38:0], 1'b0};
          state_d = StLow;
        end
      end
      StHold: begin
        if (div_end) begin
          cs_d      = 1'b1;
          bit_cnt_d = 6'd0;
          state_d   = StGap;
        end
      end
      StGap: begin
        // Gap spans two divider periods; bit_cnt marks the first one elapsed.
        if (div_end) begin
          if (bit_cnt_q == 6'd1) begin
            rdata_d   = rx_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            bit_cnt_d = 6'd0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      tx_q      <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign SPI_CLK  = sclk_q;
  assign SPI_CS   = cs_q;
  assign SPI_MOSI = tx_q[39];

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV 4 and 7) each talking to a clk-sampled slave model.
module tb_spi_master;

  localparam int DivA = 4;
  localparam int DivB = 7;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic [39:0] mosi;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  start = '0;
  logic [1:0]  wr = '0;
  logic [3:0]  addr [2];
  logic [31:0] wdata [2];
  logic [1:0]  busy, done, sclk, cs, mosi;
  logic [1:0]  miso = '0;
  logic [31:0] rdata [2];

  // Slave-model state, indexed by DUT
  int          cyc = 0;
  logic [1:0]  cs_q = 2'b11;
  logic [1:0]  sclk_q = 2'b00;
  logic [39:0] s_bits [2] = '{default: '0};
  logic [39:0] s_rx [2] = '{default: '0};
  logic [39:0] frame [2] = '{default: '0};
  logic [39:0] resp [2] = '{default: '0};
  int          edges [2] = '{default: 0};
  int          done_cnt [2] = '{default: 0};
  int          cs_run [2] = '{default: 0};
  int          gap_last [2] = '{default: 0};

  int   checks = 0;
  int   errors = 0;
  int   t0 [2];
  int   edges0 [2];
  int   dc0 [2];
  exp_t sb [$];

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(DivA)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .wr(wr[0]), .addr(addr[0]),
    .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
    .SPI_CLK(sclk[0]), .SPI_CS(cs[0]), .SPI_MOSI(mosi[0]), .SPI_MISO(miso[0])
  );

  spi_master #(.CLK_DIV(DivB)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .wr(wr[1]), .addr(addr[1]),
    .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
    .SPI_CLK(sclk[1]), .SPI_CS(cs[1]), .SPI_MOSI(mosi[1]), .SPI_MISO(miso[1])
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      cs_q[i]   <= cs[i];
      sclk_q[i] <= sclk[i];
      if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
      if (sclk_q[i] === 1'b0 && sclk[i] === 1'b1) edges[i] <= edges[i] + 1;
      if (cs[i] === 1'b1) cs_run[i] <= cs_run[i] + 1;
      if (cs_q[i] === 1'b1 && cs[i] === 1'b0) begin
        gap_last[i] <= cs_run[i];
        cs_run[i]   <= 0;
        s_bits[i]   <= resp[i];
        miso[i]     <= resp[i][39];
      end else if (cs[i] === 1'b0) begin
        if (sclk_q[i] === 1'b0 && sclk[i] === 1'b1) s_rx[i] <= {s_rx[i][38:0], mosi[i]};
        if (sclk_q[i] === 1'b1 && sclk[i] === 1'b0) begin
          s_bits[i] <= {s_bits[i][38:0], 1'b0};
          miso[i]   <= s_bits[i][38];
        end
      end
      if (cs_q[i] === 1'b0 && cs[i] === 1'b1) frame[i] <= s_rx[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input int i, input logic w, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] r, input logic [7:0] junk, input string tag);
    exp_t e;
    e.tag   = tag;
    e.rdata = r;
    e.mosi  = {w, 3'b000, a, d};
    sb.push_back(e);
    resp[i] = {junk, r};
    @(negedge clk);
    check({tag, "_done_low"}, done[i], 1'b0);
    start[i] = 1'b1;
    wr[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    @(negedge clk);
    start[i]  = 1'b0;
    wr[i]     = 1'($urandom);
    addr[i]   = 4'($urandom);
    wdata[i]  = $urandom;
    t0[i]     = cyc;
    edges0[i] = edges[i];
    dc0[i]    = done_cnt[i];
    check({tag, "_busy"}, busy[i], 1'b1);
    check({tag, "_cs"}, cs[i], 1'b0);
    check({tag, "_mosi1"}, mosi[i], w);
  endtask

  task automatic finish_frame(input int i, input int div);
    exp_t e;
    int   n;
    int   lat;
    n = 0;
    while (done[i] !== 1'b1 && n < 200 * div) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - t0[i] + 1;
    e   = sb.pop_front();
    check({e.tag, "_done"}, done[i], 1'b1);
    check({e.tag, "_busy_done"}, busy[i], 1'b0);
    check({e.tag, "_latency"}, lat, 84 * div + 1);
    check({e.tag, "_rdata"}, rdata[i], e.rdata);
    check({e.tag, "_frame"}, frame[i], e.mosi);
    check({e.tag, "_edges"}, edges[i] - edges0[i], 40);
  endtask

  initial begin
    exp_t dummy;
    int   n;
    int   d0;
    addr[0]  = '0;
    addr[1]  = '0;
    wdata[0] = '0;
    wdata[1] = '0;
    // Start held high during reset must not launch a frame
    start[0] = 1'b1;
    wr[0]    = 1'b1;
    addr[0]  = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", done[0], 1'b0);
    check("rst_cs", cs[0], 1'b1);
    check("rst_sclk", sclk[0], 1'b0);
    check("rst_mosi", mosi[0], 1'b0);
    check("rst_rdata", rdata[0], 32'h0);
    start[0] = 1'b0;
    reset_n  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_start_busy", busy[0], 1'b0);
    check("rst_start_cs", cs[0], 1'b1);

    launch(0, 1'b0, 4'h0, 32'h0000_0000, 32'hDEAD_BEEF, 8'h5A, "read");
    finish_frame(0, DivA);
    launch(0, 1'b1, 4'h1, 32'h1234_5678, 32'h0000_0001, 8'hC3, "write1");
    finish_frame(0, DivA);
    launch(0, 1'b1, 4'h2, 32'h1234_5678, 32'h8000_0000, 8'h00, "write2");
    finish_frame(0, DivA);
    launch(0, 1'b0, 4'h7, 32'hFFFF_FFFF, 32'hA5A5_0F0F, 8'hFF, "bitorder");
    finish_frame(0, DivA);

    // Second start mid-frame is ignored
    launch(0, 1'b0, 4'h5, 32'hCAFE_0000, 32'h1357_9BDF, 8'hAA, "busyprot");
    repeat (48) @(negedge clk);
    start[0] = 1'b1;
    wr[0]    = 1'b1;
    addr[0]  = 4'hA;
    @(negedge clk);
    start[0] = 1'b0;
    finish_frame(0, DivA);
    repeat (20) @(negedge clk);
    check("busyprot_idle", busy[0], 1'b0);
    check("busyprot_one_done", done_cnt[0] - dc0[0], 1);

    // Reset at bit 20
    launch(0, 1'b1, 4'h3, 32'h0BAD_F00D, 32'h7777_7777, 8'h11, "rstmid");
    n = 0;
    while (edges[0] < edges0[0] + 20 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_bit20", edges[0] - edges0[0], 20);
    d0      = done_cnt[0];
    reset_n = 1'b0;
    @(negedge clk);
    check("rstmid_cs", cs[0], 1'b1);
    check("rstmid_sclk", sclk[0], 1'b0);
    check("rstmid_busy", busy[0], 1'b0);
    check("rstmid_done", done[0], 1'b0);
    reset_n = 1'b1;
    dummy   = sb.pop_front();
    repeat (400) @(negedge clk);
    check("rstmid_no_done", done_cnt[0] - d0, 0);
    check("rstmid_idle", busy[0], 1'b0);
    launch(0, 1'b0, 4'h9, 32'h0F0F_F0F0, 32'h2468_ACE0, 8'h3C, "after_rst");
    finish_frame(0, DivA);

    // Back-to-back on the CLK_DIV=7 instance
    launch(1, 1'b1, 4'h2, 32'h1111_2222, 32'hAAAA_5555, 8'h00, "b2b0");
    finish_frame(1, DivB);
    for (int k = 1; k < 3; k++) begin
      launch(1, 1'(k), 4'(k + 4), 32'hC0DE_0000 + 32'(k), 32'h5000_0003 * 32'(k), 8'hE7,
             $sformatf("b2b%0d", k));
      finish_frame(1, DivB);
      check($sformatf("b2b%0d_gap", k), gap_last[1] >= 14, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
